rate_tick_gen: RTL and testbench
================================

RATE_TICK_GEN -- requirements
Module: rate_tick_gen

Interface
REQ-001 SHALL have parameter DIV_SLOW, default 2500000: clocks per tick when the fast key is released.
REQ-002 SHALL have parameter DIV_FAST, default 1000000: clocks per tick when the fast key is held.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable clocks needed to accept a key change.
REQ-004 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port fast_key_n, input, 1: raw, asynchronous pushbutton; low means pressed.
REQ-007 SHALL have port enable, input, 1: synchronous run enable; high lets the divider advance.
REQ-008 SHALL have port tick, output, 1: one-clock pulse per divider period; feeds the downstream counter and calendar.
REQ-009 SHALL have port tick_toggle, output, 1: level that inverts on every tick (LED heartbeat).
REQ-010 SHALL have port fast_active, output, 1: debounced key state; high means fast rate is selected.
REQ-011 SHALL have port tick_count, output, 16: number of ticks since reset, modulo 65536.

Function
REQ-012 SHALL pass fast_key_n through a 2-flop synchronizer; only the synchronized value is used.
REQ-013 SHALL keep a debounce counter: it clears when the synchronized input equals the debounced state, and increments when they differ.
REQ-014 SHALL update the debounced state when the counter reaches DEBOUNCE_CYCLES-1 while still differing, then clear the counter.
REQ-015 SHALL drive fast_active as the inverse of the debounced key level, registered.
REQ-016 SHALL compute active divisor N = DIV_FAST when fast_active=1, else DIV_SLOW.
REQ-017 SHALL hold a 32-bit div_cnt that, with enable=1, increments each clock while div_cnt < N-1.
REQ-018 SHALL, with enable=1 and div_cnt >= N-1, assert tick for exactly that clock and load div_cnt with 0.
REQ-019 SHALL make the ">=" compare cover a rate switch to fast while div_cnt already exceeds DIV_FAST-1: one tick on the next enabled clock, then wrap to 0.
REQ-020 SHALL extend a switch to slow mid-period to DIV_SLOW without any extra tick.
REQ-021 SHALL, with enable=0, hold div_cnt, keep tick=0, and hold tick_toggle and tick_count.
REQ-022 SHALL register tick as an output: it is high in the clock after div_cnt is sampled at N-1.
REQ-023 SHALL give a steady-state period of N clocks, i.e. tick high 1 clock and low N-1 clocks.
REQ-024 SHALL invert tick_toggle and increment tick_count in the same edge that raises tick.
REQ-025 SHALL wrap tick_count from 65535 to 0 with no flag.
REQ-026 SHALL require legal parameters DIV_FAST >= 2, DIV_SLOW >= 2 and DEBOUNCE_CYCLES >= 1; other values are unsupported.

Reset
REQ-027 SHALL, while reset=1 and regardless of clock, set div_cnt=0, tick=0, tick_toggle=0 and tick_count=0.
REQ-028 SHALL, while reset=1, set the debounce counter to 0, both synchronizer flops to 1, the debounced state to released, and fast_active=0.
REQ-029 SHALL abandon any partial period or pending debounce when reset asserts mid-operation; the first tick after release comes N clocks later.
REQ-030 SHALL treat reset release as synchronous to clock in the integrating design.

Verification (DIV_SLOW=5, DIV_FAST=2, DEBOUNCE_CYCLES=3)
REQ-031 SHALL cover: reset released, enable=1, key released -> tick pulses every 5 clocks, tick_toggle alternating, and tick_count=4 after 20 clocks.
REQ-032 SHALL cover: key held low -> fast_active rises 2 sync + 3 debounce clocks later, and ticks every 2 clocks thereafter.
REQ-033 SHALL cover: key glitch low for 2 clocks -> fast_active stays 0 and the tick period stays 5.
REQ-034 SHALL cover: fast becomes active with div_cnt=3 -> tick on the next enabled clock, then period 2.
REQ-035 SHALL cover: enable=0 for 7 clocks mid-period -> no tick, then the remaining count resumes unchanged.
REQ-036 SHALL cover: tick_count forced to 65535 followed by one tick -> tick_count=0; and reset asserted mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/rate_tick_gen.sv
// Rate tick generator: debounced fast/slow key selects the divider period;
// emits a one-clock tick per period plus a heartbeat toggle and a tick counter.
module rate_tick_gen #(
    parameter int unsigned DIV_SLOW        = 2500000,
    parameter int unsigned DIV_FAST        = 1000000,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fast_key_n,
    input  logic        enable,
    output logic        tick,
    output logic        tick_toggle,
    output logic        fast_active,
    output logic [15:0] tick_count
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] FAST_LAST = 32'(DIV_FAST - 1);
    localparam logic [31:0] SLOW_LAST = 32'(DIV_SLOW - 1);

    logic             key_meta;
    logic             key_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             key_differs;
    logic [31:0]      div_cnt;
    logic [31:0]      div_last;

    // fast_active doubles as the debounced state: 1 means the key is held
    // (debounced level low), so the synchronized key differs from the
    // accepted state exactly when key_sync equals fast_active.
    assign key_differs = (key_sync == fast_active);
    assign div_last    = fast_active ? FAST_LAST : SLOW_LAST;

    // Two-flop synchronizer for the raw pushbutton; idles at released (1).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= fast_key_n;
            key_sync <= key_meta;
        end
    end

    // Debounce: accept a new key level only after it has differed for
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_cnt     <= '0;
            fast_active <= 1'b0;
        end else if (!key_differs) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt     <= '0;
            fast_active <= ~key_sync;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Divider: the >= compare lets a switch to the shorter period fire
    // immediately when the count is already past the new terminal value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            tick        <= 1'b0;
            tick_toggle <= 1'b0;
            tick_count  <= '0;
        end else if (enable) begin
            if (div_cnt >= div_last) begin
                div_cnt     <= '0;
                tick        <= 1'b1;
                tick_toggle <= ~tick_toggle;
                tick_count  <= tick_count + 16'd1;
            end else begin
                div_cnt <= div_cnt + 32'd1;
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Directed bench for rate_tick_gen with small dividers; expected tick cycles
// are queued when stimulus is applied and matched as the DUT ticks.
module tb_rate_tick_gen;

    localparam int unsigned DS = 5;
    localparam int unsigned DF = 2;
    localparam int unsigned DB = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fast_key_n = 1'b1;
    logic        enable = 1'b0;
    logic        tick;
    logic        tick_toggle;
    logic        fast_active;
    logic [15:0] tick_count;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          exp_q[$];
    logic [15:0] exp_count = '0;
    logic        exp_toggle = 1'b0;

    rate_tick_gen #(
        .DIV_SLOW(DS),
        .DIV_FAST(DF),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fast_key_n(fast_key_n),
        .enable(enable),
        .tick(tick),
        .tick_toggle(tick_toggle),
        .fast_active(fast_active),
        .tick_count(tick_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expect a tick k rising edges from now.
    task automatic push(input int k);
        exp_q.push_back(cyc + k);
    endtask

    // Advance one clock and compare at the falling edge.
    task automatic step();
        logic exp_tick;
        @(negedge clock);
        exp_tick = (exp_q.size() > 0) && (exp_q[0] == cyc);
        check("tick", 32'(tick), 32'(exp_tick));
        if (exp_tick) begin
            void'(exp_q.pop_front());
            exp_count  = exp_count + 16'd1;
            exp_toggle = ~exp_toggle;
            check("tick_count", 32'(tick_count), 32'(exp_count));
            check("tick_toggle", 32'(tick_toggle), 32'(exp_toggle));
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic queue_empty(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Assert reset, confirm outputs clear immediately, release on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_tick", 32'(tick), 0);
        check("rst_toggle", 32'(tick_toggle), 0);
        check("rst_count", 32'(tick_count), 0);
        check("rst_fast", 32'(fast_active), 0);
        fast_key_n = 1'b1;
        enable     = 1'b0;
        exp_q.delete();
        exp_count  = '0;
        exp_toggle = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Slow rate, key released: period 5.
        enable = 1'b1;
        push(5); push(10); push(15); push(20);
        run(20);
        check("slow_count_20clk", 32'(tick_count), 4);
        check("slow_toggle_20clk", 32'(tick_toggle), 0);
        queue_empty("slow_queue");

        // Key held: fast after 2 sync + 3 debounce clocks, then period 2.
        fast_key_n = 1'b0;
        push(5); push(7); push(9); push(11);
        run(4);
        check("fast_before", 32'(fast_active), 0);
        run(1);
        check("fast_after", 32'(fast_active), 1);
        run(7);
        queue_empty("fast_queue");

        // Mid-run reset with fast active and a nonzero count.
        do_reset();

        // Two-clock glitch must be rejected.
        enable = 1'b1;
        fast_key_n = 1'b0;
        push(5); push(10); push(15); push(20);
        run(2);
        fast_key_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            check("glitch_fast", 32'(fast_active), 0);
        end
        queue_empty("glitch_queue");

        do_reset();

        // Fast takes effect while div_cnt=3: tick next clock, then period 2.
        fast_key_n = 1'b0;
        run(2);
        enable = 1'b1;
        push(4); push(6); push(8); push(10);
        run(2);
        check("late_fast_before", 32'(fast_active), 0);
        run(1);
        check("late_fast_after", 32'(fast_active), 1);
        run(7);
        queue_empty("late_fast_queue");

        // Key released mid-fast-period: period stretches to 5, no extra tick.
        fast_key_n = 1'b1;
        push(2); push(4); push(9); push(14);
        run(4);
        check("slow_sw_before", 32'(fast_active), 1);
        run(1);
        check("slow_sw_after", 32'(fast_active), 0);
        run(9);
        queue_empty("slow_sw_queue");

        do_reset();

        // Enable low for 7 clocks mid-period: count resumes where it stopped.
        enable = 1'b1;
        run(2);
        enable = 1'b0;
        run(7);
        enable = 1'b1;
        push(3); push(8);
        run(8);
        queue_empty("hold_queue");

        // Counter wrap from 65535.
        enable = 1'b0;
        force dut.tick_count = 16'hFFFF;
        #1;
        release dut.tick_count;
        check("wrap_preload", 32'(tick_count), 32'h0000_FFFF);
        exp_count = 16'hFFFF;
        enable = 1'b1;
        push(5);
        run(5);
        check("wrap_count", 32'(tick_count), 0);
        queue_empty("wrap_queue");

        // Reset while tick is high and toggle is set.
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
